// File: rtl/write_buffer32.sv
// ----------------------------------------------------------------------------
// write_buffer32
//   Store buffer between a CPU and a slow memory. Stores are queued in a
//   circular FIFO and drained to memory one at a time. Loads that match a
//   buffered store are forwarded from the youngest matching entry. A load
//   that misses while stores are pending stalls the CPU until the buffer is
//   fully drained, so loads never overtake older stores.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   clrn       : asynchronous active-low reset
//   cpu_we     : CPU store request (wins if cpu_re is also high)
//   cpu_re     : CPU load request
//   cpu_addr   : byte address, bits [1:0] ignored (word accesses only)
//   cpu_wdata  : store data
//   cpu_stall  : freeze CPU pc / register file while high
//   hit        : a buffered store matches the load address
//   hit_data   : forwarded load data, valid when hit is high
//   mem_req    : memory write request
//   mem_addr   : memory write address, bits [1:0] forced to zero
//   mem_wdata  : memory write data
//   mem_ack    : memory accepted the current write (one cycle per write)
//   empty      : no stores buffered
// ----------------------------------------------------------------------------
module write_buffer32 #(
   parameter int DEPTH = 4            // 2, 4 or 8
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic        cpu_we,
   input  logic        cpu_re,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_stall,
   output logic        hit,
   output logic [31:0] hit_data,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   output logic        empty
);

   localparam int PW = $clog2(DEPTH);

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;

   logic [DEPTH-1:0][29:0] r_addr;
   logic [DEPTH-1:0][31:0] r_data;
   logic [PW-1:0]          r_wr_ptr;
   logic [PW-1:0]          r_rd_ptr;
   logic [PW:0]            r_count;
   logic [PW:0]            w_count_nxt;

   logic                   w_full;
   logic                   w_nonempty;
   logic                   w_load;
   logic                   w_push;
   logic                   w_pop;
   logic [DEPTH-1:0]       w_match;
   logic [PW-1:0]          w_idx;
   logic                   w_hit;
   logic [31:0]            w_hit_data;
   logic                   w_unused;

   assign w_unused   = ^cpu_addr[1:0];

   // Full/empty come from the registered count only; a same-cycle ack does
   // not free a slot for a same-cycle store.
   assign w_full     = (r_count == (PW+1)'(DEPTH));
   assign w_nonempty = (r_count != '0);

   // A simultaneous store and load is handled as a store only.
   assign w_load     = cpu_re & ~cpu_we;

   // Per-slot address comparators (physical slot order).
   generate
      for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
         assign w_match[g] = (r_addr[g] == cpu_addr[31:2]);
      end
   endgenerate

   // Walk slots from oldest (rd_ptr) to youngest; a later match overrides,
   // so the youngest matching store supplies the data. Only the first
   // r_count slots from rd_ptr hold valid entries.
   always_comb begin
      w_hit      = 1'b0;
      w_hit_data = '0;
      w_idx      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = r_rd_ptr + PW'(k);
         if (w_load && ((PW+1)'(k) < r_count) && w_match[w_idx]) begin
            w_hit      = 1'b1;
            w_hit_data = r_data[w_idx];
         end
      end
   end

   assign hit       = w_hit;
   assign hit_data  = w_hit_data;

   // Missed load with pending stores waits for a full drain.
   assign cpu_stall = (cpu_we & w_full) | (w_load & ~w_hit & w_nonempty);

   assign w_push    = cpu_we & ~cpu_stall;
   assign w_pop     = (r_state == REQ) & mem_ack;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + (PW+1)'(1);
         2'b01:   w_count_nxt = r_count - (PW+1)'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // Drain FSM: request whenever the post-edge count is nonzero, giving
   // back-to-back requests while entries remain.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_count_nxt != '0) w_state_nxt = REQ;
         REQ:     if (w_count_nxt == '0) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_state  <= IDLE;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_count  <= w_count_nxt;
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
   end

   // Entry storage is not reset; validity is tracked by the pointers/count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_wr_ptr] <= cpu_addr[31:2];
         r_data[r_wr_ptr] <= cpu_wdata;
      end
   end

   // The head slot is never overwritten while valid, so these stay stable
   // until the acknowledging cycle.
   assign mem_req   = (r_state == REQ);
   assign mem_addr  = {r_addr[r_rd_ptr], 2'b00};
   assign mem_wdata = r_data[r_rd_ptr];
   assign empty     = ~w_nonempty;

endmodule

// File: tb/tb_write_buffer32.sv
module tb_write_buffer32;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        clrn;
   logic        cpu_we, cpu_re;
   logic [31:0] cpu_addr, cpu_wdata;
   logic        cpu_stall, hit, mem_req, empty;
   logic [31:0] hit_data, mem_addr, mem_wdata;
   logic        mem_ack;

   logic        man_ack = 1'b0;
   logic        rnd_ack = 1'b0;
   logic        rand_mode = 1'b0;
   int          rnd_wait = 0;

   int          n_chk = 0;
   int          n_err = 0;
   logic [63:0] wlog [$];
   int          mdl_cnt = 0;
   int          mdl_max = 0;

   assign mem_ack = rand_mode ? rnd_ack : man_ack;

   write_buffer32 #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .clrn      (clrn),
      .cpu_we    (cpu_we),
      .cpu_re    (cpu_re),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_stall (cpu_stall),
      .hit       (hit),
      .hit_data  (hit_data),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .empty     (empty)
   );

   always #5 clk = ~clk;

   // memory side: record every accepted write
   always @(posedge clk)
      if (clrn && mem_req && mem_ack) wlog.push_back({mem_addr, mem_wdata});

   // independent occupancy model from the observed handshakes
   always @(posedge clk or negedge clrn)
      if (!clrn) mdl_cnt <= 0;
      else mdl_cnt <= mdl_cnt + ((cpu_we && !cpu_stall) ? 1 : 0)
                              - ((mem_req && mem_ack) ? 1 : 0);

   always @(negedge clk)
      if (rand_mode && mdl_cnt > mdl_max) mdl_max = mdl_cnt;

   // random-latency memory responder (0..3 wait cycles per write)
   always @(negedge clk) begin
      if (!rand_mode) begin
         rnd_ack  = 1'b0;
         rnd_wait = $urandom_range(0, 3);
      end else if (rnd_ack) begin
         rnd_ack  = 1'b0;
         rnd_wait = $urandom_range(0, 3);
         if (mem_req && rnd_wait == 0) rnd_ack = 1'b1;
      end else if (mem_req) begin
         if (rnd_wait == 0) rnd_ack = 1'b1;
         else rnd_wait--;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic drain(input string tag);
      int g;
      g = 0;
      man_ack = 1'b1;
      #1;
      while (!empty && g < 40) begin
         cyc(); #1; g++;
      end
      man_ack = 1'b0;
      chk({tag, "_drain_empty"}, {31'd0, empty}, 32'd1);
   endtask

   initial begin
      logic [6:0] ack_v;
      logic [6:0] stall_v;
      int g;

      clrn = 1'b0; cpu_we = 1'b0; cpu_re = 1'b0;
      cpu_addr = '0; cpu_wdata = '0;
      #1;
      chk("rst_empty",   {31'd0, empty},     32'd1);
      chk("rst_mem_req", {31'd0, mem_req},   32'd0);
      chk("rst_stall",   {31'd0, cpu_stall}, 32'd0);
      chk("rst_hit",     {31'd0, hit},       32'd0);
      cyc(); clrn = 1'b1;

      // single store, zero-wait memory
      wlog.delete();
      cyc(); cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hAAAA0001; man_ack = 1'b1;
      #1; chk("t1_stall", {31'd0, cpu_stall}, 32'd0);
      cyc(); cpu_we = 1'b0;
      #1;
      chk("t1_req",   {31'd0, mem_req}, 32'd1);
      chk("t1_addr",  mem_addr,  32'h10);
      chk("t1_wdata", mem_wdata, 32'hAAAA0001);
      chk("t1_notempty", {31'd0, empty}, 32'd0);
      cyc(); #1;
      chk("t1_req_drop", {31'd0, mem_req}, 32'd0);
      chk("t1_empty",    {31'd0, empty},   32'd1);
      chk("t1_nwr", wlog.size(), 32'd1);
      man_ack = 1'b0;

      // fill to DEPTH, fifth store stalls, one ack frees a slot
      wlog.delete();
      for (int i = 0; i < 4; i++) begin
         cyc(); cpu_we = 1'b1; cpu_addr = 32'(4*i); cpu_wdata = 32'h30000000 + 32'(i);
         #1; chk("t2_fill_stall", {31'd0, cpu_stall}, 32'd0);
      end
      cyc(); cpu_addr = 32'h10; cpu_wdata = 32'h30000004;
      #1;
      chk("t2_full_stall", {31'd0, cpu_stall}, 32'd1);
      chk("t2_head0", mem_addr, 32'h0);
      cyc(); man_ack = 1'b1;
      #1; chk("t2_still_full", {31'd0, cpu_stall}, 32'd1);
      cyc(); man_ack = 1'b0;
      #1;
      chk("t2_unstall", {31'd0, cpu_stall}, 32'd0);
      chk("t2_head1", mem_addr, 32'h4);
      cyc(); cpu_we = 1'b0;
      drain("t2");
      chk("t2_nwr", wlog.size(), 32'd5);
      for (int i = 0; i < 5 && i < wlog.size(); i++) begin
         chk("t2_order_addr", wlog[i][63:32], 32'(4*i));
         chk("t2_order_data", wlog[i][31:0], 32'h30000000 + 32'(i));
      end

      // forwarding from the youngest of two matching stores
      wlog.delete();
      cyc(); cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h1;
      cyc(); cpu_wdata = 32'h2;
      cyc(); cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = 32'h23;
      #1;
      chk("t3_hit",      {31'd0, hit},       32'd1);
      chk("t3_hit_data", hit_data,           32'h2);
      chk("t3_stall",    {31'd0, cpu_stall}, 32'd0);
      cpu_addr = 32'h24;
      #1;
      chk("t3_miss_hit",   {31'd0, hit},       32'd0);
      chk("t3_miss_stall", {31'd0, cpu_stall}, 32'd1);
      // store+load together is a store: no hit, store accepted
      cyc(); cpu_we = 1'b1; cpu_re = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h3;
      #1;
      chk("t3_both_hit",   {31'd0, hit},       32'd0);
      chk("t3_both_stall", {31'd0, cpu_stall}, 32'd0);
      cyc(); cpu_we = 1'b0;
      #1;
      chk("t3_young_hit",  {31'd0, hit}, 32'd1);
      chk("t3_young_data", hit_data,     32'h3);
      cyc(); cpu_re = 1'b0;
      drain("t3");
      chk("t3_nwr", wlog.size(), 32'd3);
      if (wlog.size() == 3) chk("t3_last_data", wlog[2][31:0], 32'h3);

      // missed load stalls until both pending stores are acked
      wlog.delete();
      cyc(); cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h40;
      cyc(); cpu_addr = 32'h44; cpu_wdata = 32'h44;
      cyc(); cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = 32'h80;
      ack_v   = 7'b0100100;
      stall_v = 7'b0111111;
      for (int c = 0; c < 7; c++) begin
         if (c > 0) cyc();
         man_ack = ack_v[c];
         #1;
         chk("t4_stall", {31'd0, cpu_stall}, {31'd0, stall_v[c]});
         if (c == 2) chk("t4_addr0", mem_addr, 32'h40);
         if (c == 5) chk("t4_addr1", mem_addr, 32'h44);
      end
      chk("t4_empty", {31'd0, empty}, 32'd1);
      cyc(); cpu_re = 1'b0; man_ack = 1'b0;

      // ten stores, random ack latency, pointers wrap
      wlog.delete();
      rand_mode = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc(); cpu_we = 1'b1; cpu_addr = 32'h100 + 32'(4*i); cpu_wdata = 32'hC0DE0000 + 32'(i);
         #1;
         g = 0;
         while (cpu_stall && g < 50) begin
            cyc(); #1; g++;
         end
         chk("t5_accept", {31'd0, cpu_stall}, 32'd0);
      end
      cyc(); cpu_we = 1'b0;
      #1;
      g = 0;
      while (!empty && g < 200) begin
         cyc(); #1; g++;
      end
      chk("t5_empty", {31'd0, empty}, 32'd1);
      cyc(); rand_mode = 1'b0;
      chk("t5_nwr", wlog.size(), 32'd10);
      for (int i = 0; i < 10 && i < wlog.size(); i++) begin
         chk("t5_addr", wlog[i][63:32], 32'h100 + 32'(4*i));
         chk("t5_data", wlog[i][31:0],  32'hC0DE0000 + 32'(i));
      end
      chk("t5_max_le_depth", {31'd0, (mdl_max <= DEPTH)}, 32'd1);

      // reset mid-drain discards pending stores
      wlog.delete();
      for (int i = 0; i < 3; i++) begin
         cyc(); cpu_we = 1'b1; cpu_addr = 32'h200 + 32'(4*i); cpu_wdata = 32'(i);
      end
      cyc(); cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = 32'h204;
      #1;
      chk("t6_req_before", {31'd0, mem_req}, 32'd1);
      chk("t6_hit_before", {31'd0, hit},     32'd1);
      #2; clrn = 1'b0;
      #1;
      chk("t6_rst_req",   {31'd0, mem_req},   32'd0);
      chk("t6_rst_empty", {31'd0, empty},     32'd1);
      chk("t6_rst_hit",   {31'd0, hit},       32'd0);
      chk("t6_rst_stall", {31'd0, cpu_stall}, 32'd0);
      cyc(); man_ack = 1'b1;
      cyc(); cyc();
      cpu_re = 1'b0; man_ack = 1'b0; clrn = 1'b1;
      chk("t6_no_writes", wlog.size(), 32'd0);
      cyc(); cpu_we = 1'b1; cpu_addr = 32'h300; cpu_wdata = 32'h55;
      cyc(); cpu_we = 1'b0;
      #1;
      chk("t6_post_req",   {31'd0, mem_req}, 32'd1);
      chk("t6_post_addr",  mem_addr,  32'h300);
      chk("t6_post_wdata", mem_wdata, 32'h55);
      drain("t6");
      chk("t6_nwr", wlog.size(), 32'd1);

      cyc();
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
